// File: rtl/cpu_pkg.sv
// Shared types and constants for the Day-10 CRT instruction sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_NOOP = 2'b00,
    OP_ADDX = 2'b01,
    OP_HALT = 2'b10
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN1 = 2'b01,
    ST_RUN2 = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int CRT_W        = 40;
  localparam int CRT_H        = 6;
  localparam int FRAME_CYCLES = 240;
  localparam int SAMPLE_FIRST = 20;
  localparam int SAMPLE_STEP  = 40;
  localparam int CYC_W        = 8;

  // Any word with bit 15 set is a halt, regardless of bit 14.
  function automatic opcode_e decode_op(input logic [15:0] word);
    if (word[15]) begin
      return OP_HALT;
    end else if (word[14]) begin
      return OP_ADDX;
    end else begin
      return OP_NOOP;
    end
  endfunction

endpackage

// File: rtl/strength_acc.sv
// Signal-strength accumulator: adds cycle * X on the sampled cycles 20, 60, ..., 220.
module strength_acc
  import cpu_pkg::*;
#(
  parameter int XW = 8,
  parameter int SW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 hs,
  input  logic [CYC_W-1:0]     cycle,
  input  logic signed [XW-1:0] x,
  output logic signed [SW-1:0] strength
);

  logic signed [SW-1:0] acc_d, acc_q;
  logic signed [SW-1:0] cyc_s, x_s, prod_s;
  logic                 sample_s;

  // Sample detection and the wrapping signed multiply-accumulate.
  always_comb begin
    sample_s = ((int'(cycle) % SAMPLE_STEP) == SAMPLE_FIRST);
    cyc_s    = SW'(cycle);
    x_s      = SW'(x);
    prod_s   = cyc_s * x_s;
    acc_d    = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (hs && sample_s) begin
      acc_d = acc_q + prod_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign strength = acc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Day-10 instruction sequencer: runs noop/addx/halt from the ROM, one CRT cycle
// per pixel handshake, tracking X, the beam position and the signal strength.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int XW     = 8,
  parameter int SW     = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [15:0]          imem_data,
  output logic                 pix_valid,
  input  logic                 crt_ready,
  output logic [5:0]           pix_col,
  output logic [2:0]           pix_row,
  output logic signed [XW-1:0] sprite_x,
  output logic signed [SW-1:0] strength,
  output logic                 busy,
  output logic                 done
);

  state_e               state_d, state_q;
  logic [ADDR_W-1:0]    pc_d, pc_q;
  logic [CYC_W-1:0]     cycle_d, cycle_q;
  logic signed [XW-1:0] x_d, x_q;
  logic [5:0]           col_d, col_q;
  logic [2:0]           row_d, row_q;

  opcode_e              op_s;
  logic signed [XW-1:0] imm_s;
  logic                 hs_s, clear_s, frame_end_s, pc_last_s;

  // Next-state, counters and handshake decode.
  always_comb begin
    op_s        = decode_op(imem_data);
    imm_s       = XW'($signed(imem_data[7:0]));
    pix_valid   = ((state_q == ST_RUN1) && (op_s != OP_HALT)) || (state_q == ST_RUN2);
    hs_s        = pix_valid & crt_ready;
    frame_end_s = (cycle_q == CYC_W'(FRAME_CYCLES));
    pc_last_s   = (pc_q == '1);

    state_d = state_q;
    pc_d    = pc_q;
    cycle_d = cycle_q;
    x_d     = x_q;
    col_d   = col_q;
    row_d   = row_q;
    clear_s = 1'b0;

    // Beam and cycle count advance on every accepted CRT cycle.
    if (hs_s) begin
      cycle_d = cycle_q + 1'b1;
      if (col_q == 6'(CRT_W - 1)) begin
        col_d = 6'd0;
        row_d = (row_q == 3'(CRT_H - 1)) ? 3'd0 : row_q + 3'd1;
      end else begin
        col_d = col_q + 6'd1;
      end
    end else begin
      cycle_d = cycle_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN1;
          pc_d    = '0;
          cycle_d = CYC_W'(1);
          x_d     = XW'(1);
          col_d   = 6'd0;
          row_d   = 3'd0;
          clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN1: begin
        if (op_s == OP_HALT) begin
          state_d = ST_DONE;
        end else if (hs_s) begin
          if (op_s == OP_ADDX) begin
            state_d = ST_RUN2;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = pc_last_s ? ST_DONE : ST_RUN1;
          end
          // A full frame ends the run even in the middle of an addx.
          if (frame_end_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = state_d;
          end
        end else begin
          state_d = ST_RUN1;
        end
      end
      ST_RUN2: begin
        if (hs_s) begin
          x_d     = x_q + imm_s;
          pc_d    = pc_q + 1'b1;
          state_d = (pc_last_s || frame_end_s) ? ST_DONE : ST_RUN1;
        end else begin
          state_d = ST_RUN2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cycle_q <= CYC_W'(1);
      x_q     <= XW'(1);
      col_q   <= 6'd0;
      row_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cycle_q <= cycle_d;
      x_q     <= x_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  strength_acc #(
    .XW(XW),
    .SW(SW)
  ) u_strength_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .hs      (hs_s),
    .cycle   (cycle_q),
    .x       (x_q),
    .strength(strength)
  );

  assign imem_addr = pc_q;
  assign pix_col   = col_q;
  assign pix_row   = row_q;
  assign sprite_x  = x_q;
  assign busy      = (state_q == ST_RUN1) || (state_q == ST_RUN2);
  assign done      = (state_q == ST_DONE);

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the Day-10 CRT design.
- Fetches `noop`/`addx`/`halt` words from a combinational program ROM and executes them at one CRT cycle per handshake (`addx` takes two cycles).
- Maintains the X register and the beam position, and presents one pixel request per cycle to the CRT pixel stage.
- Accumulates the puzzle's signal-strength sum along the way.

## Interface
Parameters:
- `ADDR_W`, 8: program ROM address width.
- `XW`, 8: signed X register width.
- `SW`, 24: signed signal-strength accumulator width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous assertion, active-low.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `imem_addr`  out  ADDR_W  program counter, drives ROM address.
- `imem_data`  in  16  instruction word, combinational from ROM.
  - [15:14] opcode: 00 noop, 01 addx, 1x halt.
  - [7:0] signed immediate.
- `pix_valid`  out  1  a CRT cycle is presented this clock.
- `crt_ready`  in  1  CRT stage accepts the cycle.
- `pix_col`  out  6  beam column 0..39.
- `pix_row`  out  3  beam row 0..5.
- `sprite_x`  out  XW signed  X value *during* the presented cycle.
- `strength`  out  SW signed  running signal-strength sum.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next `start` or reset.

## Operation
- States: IDLE, RUN1 (first/only cycle of an instruction), RUN2 (second cycle of `addx`), DONE.
- IDLE / DONE + `start` → RUN1. The same edge sets:
  - pc = 0, cycle = 1, X = 1
  - col = 0, row = 0
  - strength = 0, `done` = 0
- `start` while busy is ignored.
- `pix_valid` = (RUN1 and opcode ≠ halt) or RUN2. It is combinational from state and `imem_data`.
- The handshake is `pix_valid & crt_ready`. Nothing advances without it, and all outputs hold stable while stalled.
- RUN1 on handshake:
  - noop → pc+1, stay RUN1.
  - addx → RUN2, pc unchanged.
- RUN1 with a halt opcode → DONE next edge. It consumes no CRT cycle.
- RUN2 on handshake: X ← X + imm (two's-complement wrap at XW bits), pc+1, → RUN1.
  - The new X is visible starting with the next cycle, never the current one.
- Every handshake:
  - cycle+1.
  - col+1; at 39, col → 0 and row+1.
  - If cycle mod 40 == 20 (cycles 20, 60, …, 220): strength ← strength + cycle × X, using the X before any update on this edge. The multiply is signed and SW-bit wrapping.
- Termination → DONE, `busy` = 0, `done` = 1. A run ends on:
  - a halt opcode;
  - the handshake of cycle 240 (frame full), even mid-addx;
  - a pc increment past 2^ADDR_W − 1.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `pix_valid` 0
  - `imem_addr` 0, `pix_col` 0, `pix_row` 0
  - `sprite_x` 1, `strength` 0
- Reset mid-run aborts immediately to these values. No pixel is emitted after reset.
- First `pix_valid` is one clock after `start`.
- With `crt_ready` tied high:
  - noop occupies 1 clock; addx occupies 2 clocks.
  - `done` rises one clock after the halt word is reached.
- `strength` updates on the handshake edge of the sampled cycle. It is valid and stable once `done` = 1.
- `start` and termination on the same edge: the termination wins; `start` is ignored.

## Structure
- Package `cpu_pkg` contains:
  - opcode enum
  - state enum
  - CRT_W = 40, CRT_H = 6, FRAME_CYCLES = 240
  - SAMPLE_FIRST = 20, SAMPLE_STEP = 40
- One sub-module, `strength_acc`:
  - inputs: handshake, cycle, X, clear.
  - owns the sample-cycle detection, the multiply and the SW-bit accumulator.
- Sequencer FSM, pc, cycle and beam counters stay in `cpu_sequencer`.

## Test plan
- Program {noop, addx 3, addx −5, halt}, ready high → `sprite_x` sequence 1, 1, 1, 4, 4; `done` after 5 cycles; final X = −1.
- AoC example program (146 instructions), ready high → `strength` = 13140 at `done`; `pix_row` reached 5, `pix_col` 39.
- Same small program with `crt_ready` toggled randomly → identical `sprite_x`/col/row sequence; outputs stable on every stall clock.
- Long noop program (300 words) → DONE exactly at handshake 240; no `pix_valid` afterwards.
- Reset asserted during RUN2 of an addx → all outputs at reset values; a new `start` reproduces the full sequence from X = 1.
- `start` pulsed while busy → ignored; `start` in DONE → run restarts with `strength` cleared to 0.
